// File: rtl/uart_program_loader_pkg.sv
// Shared types and constants for the UART program loader.
// Optional feature macro: LOADER_CHECKSUM_EN adds the CSUM frame state.
package loader_pkg;

  localparam logic [7:0] LOADER_HEADER = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
`ifdef LOADER_CHECKSUM_EN
    CSUM,
`endif
    DONE,
    ERROR
  } loader_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_BITS,
    RX_STOP
  } rx_state_e;

  // Bit period in clocks, rounded to nearest, never below 4 so mid-bit sampling stays meaningful.
  function automatic int clks_per_bit(input int clkHz, input int baud);
    int r;
    r = (clkHz + baud / 2) / baud;
    return (r < 4) ? 4 : r;
  endfunction

endpackage

// File: rtl/uart_program_loader_uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, framing check and a per-bit-time tick.
module uart_rx
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_data_o,
  output logic       frame_err_o,
  output logic       bit_tick_o
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_e state_q, state_d;
  logic          sync1_q, sync2_q, prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] tickCnt_q;
  logic [2:0]    bitIdx_q, bitIdx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      prev_q    <= 1'b1;
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      tickCnt_q <= '0;
      bitIdx_q  <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      sync1_q   <= rx_i;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tickCnt_q <= (tickCnt_q == LAST_CNT) ? '0 : tickCnt_q + 1'b1;
      bitIdx_q  <= bitIdx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  // A start bit that reads high at its mid-point was a glitch and is dropped.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    bitIdx_d = bitIdx_q;
    shift_d  = shift_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (prev_q && !sync2_q) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d    = '0;
          bitIdx_d = '0;
          state_d  = sync2_q ? RX_IDLE : RX_BITS;
        end
      end
      RX_BITS: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d    = '0;
          shift_d  = {sync2_q, shift_q[7:1]};
          bitIdx_d = bitIdx_q + 1'b1;
          if (bitIdx_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (sync2_q) begin
            valid_d = 1'b1;
            data_d  = shift_q;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_valid_o = valid_q;
  assign byte_data_o  = data_q;
  assign frame_err_o  = ferr_q;
  assign bit_tick_o   = (tickCnt_q == LAST_CNT);

endmodule

// File: rtl/uart_program_loader.sv
// Loads a program image from UART into instruction memory while holding the core in reset.
// Optional feature macro: LOADER_CHECKSUM_EN appends and verifies an XOR checksum byte.
module uart_program_loader
  import loader_pkg::*;
#(
  parameter int CLK_HZ   = 12000000,
  parameter int BAUD     = 115200,
  parameter int ADDR_W   = 10,
  parameter int GAP_BITS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_hold,
  output logic              load_done,
  output logic              load_error
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
  localparam int GW = $clog2(GAP_BITS + 2) + 1;
  localparam logic [GW-1:0] GAP_LIMIT = GW'(GAP_BITS);
  localparam logic [16:0]   MAX_WORDS = 17'(2 ** ADDR_W);

  logic       byteValid, frameErr, bitTick;
  logic [7:0] byteData;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) uRx (
    .clk          (clk),
    .rst          (rst),
    .rx_i         (uart_rx),
    .byte_valid_o (byteValid),
    .byte_data_o  (byteData),
    .frame_err_o  (frameErr),
    .bit_tick_o   (bitTick)
  );

  loader_state_e state_q, state_d;
  logic              memWe_q, memWe_d;
  logic [ADDR_W-1:0] memAddr_q, memAddr_d;
  logic [31:0]       memWdata_q, memWdata_d;
  logic              coreHold_q, coreHold_d;
  logic              loadDone_q, loadDone_d;
  logic              loadError_q, loadError_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   wordCnt_q, wordCnt_d;
  logic [1:0]        byteIdx_q, byteIdx_d;
  logic [23:0]       asm_q, asm_d;
  logic [7:0]        countLo_q, countLo_d;
  logic [15:0]       count_q, count_d;
  logic [GW-1:0]     gap_q, gap_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic        active, lastWord;
  logic [15:0] nextCount;

  assign active    = !(state_q inside {IDLE, DONE, ERROR});
  assign nextCount = {byteData, countLo_q};
  assign lastWord  = ({{(15 - ADDR_W){1'b0}}, wordCnt_q} + 16'd1) == count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      memWe_q     <= 1'b0;
      memAddr_q   <= '0;
      memWdata_q  <= '0;
      coreHold_q  <= 1'b1;
      loadDone_q  <= 1'b0;
      loadError_q <= 1'b0;
      addr_q      <= '0;
      wordCnt_q   <= '0;
      byteIdx_q   <= '0;
      asm_q       <= '0;
      countLo_q   <= '0;
      count_q     <= '0;
      gap_q       <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      memWe_q     <= memWe_d;
      memAddr_q   <= memAddr_d;
      memWdata_q  <= memWdata_d;
      coreHold_q  <= coreHold_d;
      loadDone_q  <= loadDone_d;
      loadError_q <= loadError_d;
      addr_q      <= addr_d;
      wordCnt_q   <= wordCnt_d;
      byteIdx_q   <= byteIdx_d;
      asm_q       <= asm_d;
      countLo_q   <= countLo_d;
      count_q     <= count_d;
      gap_q       <= gap_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  // Sitting in DONE releases the core one cycle after entry; a checksum match releases it directly.
  always_comb begin
    state_d     = state_q;
    memWe_d     = 1'b0;
    memAddr_d   = memAddr_q;
    memWdata_d  = memWdata_q;
    coreHold_d  = coreHold_q;
    loadDone_d  = loadDone_q;
    loadError_d = loadError_q;
    addr_d      = addr_q;
    wordCnt_d   = wordCnt_q;
    byteIdx_d   = byteIdx_q;
    asm_d       = asm_q;
    countLo_d   = countLo_q;
    count_d     = count_q;
    gap_d       = gap_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif

    if (state_q == DONE) begin
      coreHold_d = 1'b0;
      loadDone_d = 1'b1;
    end

    if (!active || byteValid || frameErr) gap_d = '0;
    else if (bitTick) gap_d = gap_q + 1'b1;

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (byteValid && byteData == LOADER_HEADER) begin
          state_d     = LEN0;
          coreHold_d  = 1'b1;
          loadDone_d  = 1'b0;
          loadError_d = 1'b0;
          addr_d      = '0;
          wordCnt_d   = '0;
          byteIdx_d   = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_d      = '0;
`endif
        end
      end
      LEN0: begin
        if (byteValid) begin
          countLo_d = byteData;
          state_d   = LEN1;
`ifdef LOADER_CHECKSUM_EN
          csum_d    = csum_q ^ byteData;
`endif
        end
      end
      LEN1: begin
        if (byteValid) begin
          count_d = nextCount;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = csum_q ^ byteData;
`endif
          if ({1'b0, nextCount} > MAX_WORDS) begin
            state_d     = ERROR;
            loadError_d = 1'b1;
          end else if (nextCount == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = DONE;
`endif
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (byteValid) begin
          byteIdx_d = byteIdx_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
          csum_d    = csum_q ^ byteData;
`endif
          case (byteIdx_q)
            2'd0: asm_d[7:0]   = byteData;
            2'd1: asm_d[15:8]  = byteData;
            2'd2: asm_d[23:16] = byteData;
            default: begin
              memWe_d    = 1'b1;
              memAddr_d  = addr_q;
              memWdata_d = {byteData, asm_q};
              addr_d     = addr_q + 1'b1;
              wordCnt_d  = wordCnt_q + 1'b1;
              if (lastWord) begin
`ifdef LOADER_CHECKSUM_EN
                state_d = CSUM;
`else
                state_d = DONE;
`endif
              end
            end
          endcase
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CSUM: begin
        if (byteValid) begin
          if (byteData == csum_q) begin
            state_d    = DONE;
            coreHold_d = 1'b0;
            loadDone_d = 1'b1;
          end else begin
            state_d     = ERROR;
            loadError_d = 1'b1;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    if (active && (frameErr || gap_q > GAP_LIMIT)) begin
      state_d     = ERROR;
      loadError_d = 1'b1;
    end
  end

  assign mem_we     = memWe_q;
  assign mem_addr   = memAddr_q;
  assign mem_wdata  = memWdata_q;
  assign core_hold  = coreHold_q;
  assign load_done  = loadDone_q;
  assign load_error = loadError_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Scoreboard bench for uart_program_loader; honours LOADER_CHECKSUM_EN when defined.
module tb_uart_program_loader;

  localparam int CPB = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        uart_rx;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        core_hold, load_done, load_error;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t  expQ[$];
  int   checks = 0;
  int   passes = 0;
  logic mDone = 1'b0;
  logic mErr  = 1'b0;
  logic prevWe = 1'b0;

  uart_program_loader #(
    .CLK_HZ(1000000), .BAUD(100000), .ADDR_W(10), .GAP_BITS(256)
  ) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_hold(core_hold), .load_done(load_done), .load_error(load_error)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every write strobe is matched against the oldest expected write.
  always @(negedge clk) begin
    if (rst && mem_we) begin
      checkOutput("mem_we pulse width", {31'b0, prevWe}, 32'd0);
      if (expQ.size() == 0) begin
        checkOutput("unexpected mem_we", {31'b0, mem_we}, 32'd0);
      end else begin
        wr_t e;
        e = expQ.pop_front();
        checkOutput("write addr", {22'b0, mem_addr}, {22'b0, e.addr});
        checkOutput("write data", mem_wdata, e.data);
      end
    end
    prevWe = rst && mem_we;
  end

  task automatic sendByte(input logic [7:0] b, input logic stopBit);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stopBit;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] s[$]);
    foreach (s[i]) sendByte(s[i], 1'b1);
  endtask

  // Frame-level reference: scans a byte stream by the protocol rules and queues expected writes.
  task automatic modelStream(input logic [7:0] s[$]);
    int i;
    int cnt;
    logic [7:0] x;
    i = 0;
    while (i < s.size()) begin
      if (s[i] != 8'hA5) begin
        i++;
        continue;
      end
      i++;
      mDone = 1'b0;
      mErr  = 1'b0;
      cnt = {s[i+1], s[i]};
      x = s[i] ^ s[i+1];
      i += 2;
      if (cnt > 1024) begin
        mErr = 1'b1;
        continue;
      end
      for (int w = 0; w < cnt; w++) begin
        wr_t e;
        e.addr = w[9:0];
        e.data = {s[i+3], s[i+2], s[i+1], s[i]};
        x = x ^ s[i] ^ s[i+1] ^ s[i+2] ^ s[i+3];
        expQ.push_back(e);
        i += 4;
      end
`ifdef LOADER_CHECKSUM_EN
      if (s[i] == x) mDone = 1'b1;
      else mErr = 1'b1;
      i++;
`else
      mDone = 1'b1;
`endif
    end
  endtask

  function automatic logic [7:0] xorTail(input logic [7:0] s[$]);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 1; i < s.size(); i++) x = x ^ s[i];
    return x;
  endfunction

  task automatic checkStatus(input string tag);
    repeat (20) @(negedge clk);
    checkOutput({tag, " load_done"}, {31'b0, load_done}, {31'b0, mDone});
    checkOutput({tag, " load_error"}, {31'b0, load_error}, {31'b0, mErr});
    checkOutput({tag, " core_hold"}, {31'b0, core_hold}, {31'b0, ~mDone});
    checkOutput({tag, " pending writes"}, expQ.size(), 32'd0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " mem_we"}, {31'b0, mem_we}, 32'd0);
    checkOutput({tag, " mem_addr"}, {22'b0, mem_addr}, 32'd0);
    checkOutput({tag, " mem_wdata"}, mem_wdata, 32'd0);
    checkOutput({tag, " core_hold"}, {31'b0, core_hold}, 32'd1);
    checkOutput({tag, " load_done"}, {31'b0, load_done}, 32'd0);
    checkOutput({tag, " load_error"}, {31'b0, load_error}, 32'd0);
  endtask

  initial begin
    logic [7:0] f[$];
    rst = 1'b0;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    rst = 1'b1;
    repeat (200) @(negedge clk);
    checkStatus("idle");

    $display("[TB] two-word frame");
    f = {8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef LOADER_CHECKSUM_EN
    f.push_back(xorTail(f));
`endif
    modelStream(f);
    applyStimulus(f);
    checkStatus("two-word");

    $display("[TB] leading junk, zero count");
    f = {8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
    f.push_back(8'h00);
`endif
    modelStream(f);
    applyStimulus(f);
    checkStatus("zero-count");

    $display("[TB] count 1025");
    f = {8'hA5, 8'h01, 8'h04};
    modelStream(f);
    applyStimulus(f);
    checkStatus("count-1025");

`ifdef LOADER_CHECKSUM_EN
    $display("[TB] bad checksum then good");
    f = {8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h06};
    modelStream(f);
    applyStimulus(f);
    checkStatus("bad-csum");
    f = {8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    modelStream(f);
    applyStimulus(f);
    checkStatus("good-csum");
`endif

    $display("[TB] framing error mid-frame");
    applyStimulus({8'hA5, 8'h01, 8'h00, 8'h11});
    sendByte(8'h22, 1'b0);
    mDone = 1'b0;
    mErr  = 1'b1;
    checkStatus("frame-err");

    $display("[TB] gap timeout");
    applyStimulus({8'hA5, 8'h01});
    repeat (300 * CPB) @(negedge clk);
    mDone = 1'b0;
    mErr  = 1'b1;
    checkStatus("gap");

    $display("[TB] random frames");
    for (int n = 0; n < 6; n++) begin
      int cnt;
      cnt = $urandom_range(0, 4);
      f = {8'hA5, 8'(cnt), 8'h00};
      for (int b = 0; b < 4 * cnt; b++) f.push_back(8'($urandom_range(0, 255)));
`ifdef LOADER_CHECKSUM_EN
      f.push_back(xorTail(f) ^ (($urandom_range(0, 2) == 0) ? 8'h01 : 8'h00));
`endif
      modelStream(f);
      applyStimulus(f);
      checkStatus("random");
    end

    $display("[TB] reset mid-word");
    f = {8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE};
    expQ.push_back('{addr: 10'd0, data: 32'h12345678});
    applyStimulus(f);
    checkOutput("mid-word pending writes", expQ.size(), 32'd0);
    rst = 1'b0;
    #1;
    checkResetValues("mid-word reset");
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (50) @(negedge clk);
    mDone = 1'b0;
    mErr  = 1'b0;
    checkStatus("after reset");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
